miriscv_data2apb_bridge: RTL and testbench

- Protocol-correct bridge between the core data-memory interface (req/we/be/addr/wdata in, rvalid/rdata back) and an APB4 peripheral bus.
- Responds to the core as a memory slave and drives APB as the master: proper SETUP and ACCESS phases, PREADY wait states, PSLVERR, and a bounded-wait timeout.
- Sits between the SoC address decoder and the peripheral region (UART, timer). It replaces the single-cycle PSEL=PENABLE shortcut and the fixed one-cycle rvalid.

---
 rtl/miriscv_pkg.sv | 20 ++
 rtl/miriscv_data2apb_bridge_if.sv | 53 +++++
 rtl/miriscv_data2apb_bridge.sv | 120 ++++++++++++
 tb/tb_miriscv_data2apb_bridge.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/miriscv_pkg.sv
// -----------------------------------------------------------------------------
// miriscv_pkg
// Shared core-wide constants and types.
//   XLEN                 : core data / address width
//   APB_TIMEOUT_DEFAULT  : default bound on APB ACCESS wait cycles
//   apb_bridge_state_e   : state encoding of the data-to-APB bridge
// -----------------------------------------------------------------------------
package miriscv_pkg;

  localparam int XLEN                = 32;
  localparam int APB_TIMEOUT_DEFAULT = 255;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_bridge_state_e;

endpackage : miriscv_pkg

// File: rtl/miriscv_data2apb_bridge_if.sv
// -----------------------------------------------------------------------------
// miriscv_data2apb_bridge_if
// Bundles the core data-memory port and the APB4 master port of the bridge.
//   slave  modport : the bridge's view (memory slave towards the core,
//                    APB master towards the peripherals)
//   master modport : the environment's view (core + APB peripheral)
// Core side : data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
//             data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o
// APB side  : paddr_o, psel_o, penable_o, pwrite_o, pwdata_o, pstrb_o,
//             prdata_i, pready_i, pslverr_i
// -----------------------------------------------------------------------------
interface miriscv_data2apb_bridge_if #(
  parameter int XLEN       = miriscv_pkg::XLEN,
  parameter int APB_ADDR_W = 12
);

  // core data-memory interface
  logic                  data_req_i;
  logic                  data_we_i;
  logic [XLEN/8-1:0]     data_be_i;
  logic [XLEN-1:0]       data_addr_i;
  logic [XLEN-1:0]       data_wdata_i;
  logic                  data_gnt_o;
  logic                  data_rvalid_o;
  logic [XLEN-1:0]       data_rdata_o;
  logic                  data_err_o;

  // APB4 bus
  logic [APB_ADDR_W-1:0] paddr_o;
  logic                  psel_o;
  logic                  penable_o;
  logic                  pwrite_o;
  logic [XLEN-1:0]       pwdata_o;
  logic [XLEN/8-1:0]     pstrb_o;
  logic [XLEN-1:0]       prdata_i;
  logic                  pready_i;
  logic                  pslverr_i;

  modport slave (
    input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    output data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
    output paddr_o, psel_o, penable_o, pwrite_o, pwdata_o, pstrb_o,
    input  prdata_i, pready_i, pslverr_i
  );

  modport master (
    output data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    input  data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
    input  paddr_o, psel_o, penable_o, pwrite_o, pwdata_o, pstrb_o,
    output prdata_i, pready_i, pslverr_i
  );

endinterface : miriscv_data2apb_bridge_if

// File: rtl/miriscv_data2apb_bridge.sv
// -----------------------------------------------------------------------------
// miriscv_data2apb_bridge
// Bridges the core data-memory port to an APB4 bus with full SETUP/ACCESS
// phasing, PREADY wait states, PSLVERR reporting and a bounded-wait timeout.
// Ports:
//   clk_i  : clock
//   arst_i : asynchronous reset, active-high
//   bus    : miriscv_data2apb_bridge_if.slave (core port + APB master port)
// Every core-facing output is decoded from the state register or taken from
// registered fields, so prdata_i/pready_i/pslverr_i never reach the core
// combinationally.
// -----------------------------------------------------------------------------
module miriscv_data2apb_bridge
  import miriscv_pkg::*;
#(
  parameter int              XLEN           = miriscv_pkg::XLEN,
  parameter int              APB_ADDR_W     = 12,
  parameter int              TIMEOUT_CYCLES = APB_TIMEOUT_DEFAULT,
  parameter logic [XLEN-1:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
  input  logic                        clk_i,
  input  logic                        arst_i,
  miriscv_data2apb_bridge_if.slave    bus
);

  // A zero timeout still needs a legal one-bit counter.
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  apb_bridge_state_e     r_state;
  logic [APB_ADDR_W-1:0] r_addr;
  logic                  r_we;
  logic [XLEN/8-1:0]     r_be;
  logic [XLEN-1:0]       r_wdata;
  logic [XLEN-1:0]       r_rdata;
  logic                  r_err;
  logic [CNT_W-1:0]      r_cnt;

  logic                  w_timeout;
  logic                  w_unused;

  // Only the low address bits select an APB register.
  assign w_unused  = ^bus.data_addr_i[XLEN-1:APB_ADDR_W];

  // Abort on the cycle the counter reaches TIMEOUT_CYCLES-1, giving exactly
  // TIMEOUT_CYCLES ACCESS cycles before PSEL drops.
  assign w_timeout = (TIMEOUT_CYCLES != 0) &&
                     (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Core-side outputs: gnt only in IDLE so the held request is ignored in RESP.
  assign bus.data_gnt_o    = (r_state == IDLE) & bus.data_req_i;
  assign bus.data_rvalid_o = (r_state == RESP);
  assign bus.data_rdata_o  = r_rdata;
  assign bus.data_err_o    = r_err;

  // APB outputs come straight from state and the latched request, so they
  // stay stable from SETUP through the final ACCESS cycle.
  assign bus.psel_o    = (r_state == SETUP) || (r_state == ACCESS);
  assign bus.penable_o = (r_state == ACCESS);
  assign bus.paddr_o   = r_addr;
  assign bus.pwrite_o  = r_we;
  assign bus.pwdata_o  = r_wdata;
  assign bus.pstrb_o   = r_we ? r_be : '0;   // reads carry no strobes

  // Bridge FSM: request capture, APB phasing, wait/timeout, response.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_be    <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (bus.data_req_i) begin
            r_addr  <= bus.data_addr_i[APB_ADDR_W-1:0];
            r_we    <= bus.data_we_i;
            r_be    <= bus.data_be_i;
            r_wdata <= bus.data_wdata_i;
            r_state <= SETUP;
          end
        end
        SETUP: begin
          r_state <= ACCESS;
        end
        ACCESS: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (bus.pready_i) begin
            // Error wins over direction; writes return zero otherwise.
            if (bus.pslverr_i) begin
              r_rdata <= ERR_RDATA;
            end else if (r_we) begin
              r_rdata <= '0;
            end else begin
              r_rdata <= bus.prdata_i;
            end
            r_err   <= bus.pslverr_i;
            r_state <= RESP;
          end else if (w_timeout) begin
            r_rdata <= ERR_RDATA;
            r_err   <= 1'b1;
            r_state <= RESP;
          end
        end
        RESP: begin
          r_cnt   <= '0;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule : miriscv_data2apb_bridge

// File: tb/tb_miriscv_data2apb_bridge.sv
// -----------------------------------------------------------------------------
// tb_miriscv_data2apb_bridge
// Self-checking bench: a table of directed transfers with hand-computed APB
// fields, completion latency and response, plus hand-written sequences for
// late PREADY after timeout, back-to-back requests and reset mid-transfer.
// -----------------------------------------------------------------------------
module tb_miriscv_data2apb_bridge;

  logic clk;
  logic rst;

  int n_vec;
  int n_err;

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          waits;     // wait states before PREADY (large = never)
    logic [31:0] prdata;
    logic        slverr;
    logic [11:0] exp_paddr;
    logic [3:0]  exp_pstrb;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;   // cycles from gnt to rvalid
    int          exp_acc;   // number of ACCESS cycles
  } vec_t;

  vec_t vecs [7];

  miriscv_data2apb_bridge_if #(.XLEN(32), .APB_ADDR_W(12)) bus ();

  miriscv_data2apb_bridge #(
    .XLEN           (32),
    .APB_ADDR_W     (12),
    .TIMEOUT_CYCLES (4),
    .ERR_RDATA      (32'hDEAD_BEEF)
  ) dut (
    .clk_i  (clk),
    .arst_i (rst),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      $display("FAIL %s: got %h, expected %h", name, act, exp);
      n_err++;
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int cyc;
    int n_acc;
    bit done;
    bit stable_ok;
    bit gnt_extra;
    @(negedge clk);
    bus.data_req_i   = 1'b1;
    bus.data_we_i    = v.we;
    bus.data_be_i    = v.be;
    bus.data_addr_i  = v.addr;
    bus.data_wdata_i = v.wdata;
    bus.pready_i     = 1'b0;
    bus.pslverr_i    = 1'b0;
    bus.prdata_i     = 32'h0;
    #1;
    n_vec++;
    chk($sformatf("v%0d_gnt", idx), {31'd0, bus.data_gnt_o}, 32'd1);
    chk($sformatf("v%0d_psel0", idx), {31'd0, bus.psel_o}, 32'd0);
    cyc = 0; n_acc = 0; done = 1'b0; stable_ok = 1'b1; gnt_extra = 1'b0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      #1;
      if (bus.data_gnt_o) gnt_extra = 1'b1;
      if (cyc == 1) begin
        chk($sformatf("v%0d_setup", idx), {30'd0, bus.psel_o, bus.penable_o}, 32'd2);
      end
      if (bus.psel_o) begin
        if (bus.paddr_o !== v.exp_paddr || bus.pstrb_o !== v.exp_pstrb ||
            bus.pwrite_o !== v.we || (v.we && bus.pwdata_o !== v.wdata))
          stable_ok = 1'b0;
      end
      if (bus.penable_o) begin
        n_acc++;
        if (n_acc == v.waits + 1) begin
          bus.pready_i  = 1'b1;
          bus.prdata_i  = v.prdata;
          bus.pslverr_i = v.slverr;
        end else begin
          // pslverr without pready must be ignored
          bus.pready_i  = 1'b0;
          bus.prdata_i  = 32'h5A5A_5A5A;
          bus.pslverr_i = 1'b1;
        end
      end
      if (bus.data_rvalid_o) begin
        done = 1'b1;
        chk($sformatf("v%0d_lat", idx), cyc, v.exp_lat);
        chk($sformatf("v%0d_rdata", idx), bus.data_rdata_o, v.exp_rdata);
        chk($sformatf("v%0d_err", idx), {31'd0, bus.data_err_o}, {31'd0, v.exp_err});
        chk($sformatf("v%0d_resp_psel", idx), {30'd0, bus.psel_o, bus.penable_o}, 32'd0);
        bus.data_req_i = 1'b0;
        bus.pready_i   = 1'b0;
        bus.pslverr_i  = 1'b0;
      end
    end
    if (!done) begin
      $display("FAIL v%0d_rvalid_timeout: got no rvalid in 40 cycles, expected one", idx);
      n_err++;
      bus.data_req_i = 1'b0;
    end
    chk($sformatf("v%0d_nacc", idx), n_acc, v.exp_acc);
    chk($sformatf("v%0d_apb_stable", idx), {31'd0, stable_ok}, 32'd1);
    chk($sformatf("v%0d_no_regnt", idx), {31'd0, gnt_extra}, 32'd0);
  endtask

  initial begin : main
    logic [11:0] gnt_mask;
    logic [11:0] rv_mask;
    bit          bad;
    n_vec = 0;
    n_err = 0;

    //            we   be       addr           wdata          waits prdata         err  paddr    pstrb    rdata          eerr lat acc
    vecs[0] = '{1'b0, 4'b1111, 32'h8000_0004, 32'h0000_0000, 0,    32'h1234_5678, 1'b0, 12'h004, 4'b0000, 32'h1234_5678, 1'b0, 3, 1};
    vecs[1] = '{1'b1, 4'b0011, 32'h8000_1008, 32'hA5A5_0F0F, 3,    32'hFFFF_FFFF, 1'b0, 12'h008, 4'b0011, 32'h0000_0000, 1'b0, 6, 4};
    vecs[2] = '{1'b0, 4'b1111, 32'h8000_0010, 32'h0000_0000, 0,    32'h1111_2222, 1'b1, 12'h010, 4'b0000, 32'hDEAD_BEEF, 1'b1, 3, 1};
    vecs[3] = '{1'b0, 4'b1111, 32'h8000_0FFC, 32'h0000_0000, 1000, 32'h0000_0000, 1'b0, 12'hFFC, 4'b0000, 32'hDEAD_BEEF, 1'b1, 6, 4};
    vecs[4] = '{1'b1, 4'b1111, 32'h0000_0ABC, 32'h0BAD_F00D, 1,    32'h0000_0000, 1'b1, 12'hABC, 4'b1111, 32'hDEAD_BEEF, 1'b1, 4, 2};
    vecs[5] = '{1'b0, 4'b0101, 32'h1234_5678, 32'h7777_7777, 2,    32'hCAFE_F00D, 1'b0, 12'h678, 4'b0000, 32'hCAFE_F00D, 1'b0, 5, 3};
    vecs[6] = '{1'b1, 4'b1000, 32'h0000_0001, 32'h8100_0000, 0,    32'h0000_0000, 1'b0, 12'h001, 4'b1000, 32'h0000_0000, 1'b0, 3, 1};

    rst              = 1'b1;
    bus.data_req_i   = 1'b0;
    bus.data_we_i    = 1'b0;
    bus.data_be_i    = 4'b0000;
    bus.data_addr_i  = 32'h0;
    bus.data_wdata_i = 32'h0;
    bus.prdata_i     = 32'h0;
    bus.pready_i     = 1'b0;
    bus.pslverr_i    = 1'b0;

    // Reset state: every output zero.
    repeat (2) @(negedge clk);
    #1;
    n_vec++;
    chk("reset_ctrl", {26'd0, bus.data_gnt_o, bus.data_rvalid_o, bus.data_err_o,
                       bus.psel_o, bus.penable_o, bus.pwrite_o}, 32'd0);
    chk("reset_rdata", bus.data_rdata_o, 32'd0);
    chk("reset_apb", {16'd0, bus.paddr_o, bus.pstrb_o}, 32'd0);
    chk("reset_pwdata", bus.pwdata_o, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      run_vec(vecs[i], i);
      if (i == 3) begin
        // Late PREADY one cycle after the timeout abort must have no effect.
        bus.pready_i  = 1'b1;
        bus.pslverr_i = 1'b1;
        bus.prdata_i  = 32'h0102_0304;
        @(negedge clk);
        #1;
        n_vec++;
        chk("late_pready_ctrl", {29'd0, bus.data_rvalid_o, bus.psel_o, bus.penable_o}, 32'd0);
        chk("late_pready_rdata", bus.data_rdata_o, 32'hDEAD_BEEF);
        bus.pready_i  = 1'b0;
        bus.pslverr_i = 1'b0;
      end
    end

    // Back-to-back: request held for three zero-wait reads.
    @(negedge clk);
    bus.data_req_i  = 1'b1;
    bus.data_we_i   = 1'b0;
    bus.data_be_i   = 4'b1111;
    bus.data_addr_i = 32'h8000_0040;
    bus.pready_i    = 1'b1;
    bus.pslverr_i   = 1'b0;
    bus.prdata_i    = 32'h0BAD_CAFE;
    gnt_mask = 12'd0;
    rv_mask  = 12'd0;
    for (int c = 0; c < 12; c++) begin
      if (c != 0) @(negedge clk);
      #1;
      gnt_mask[c] = bus.data_gnt_o;
      rv_mask[c]  = bus.data_rvalid_o;
      if (c == 11) bus.data_req_i = 1'b0;
    end
    bus.pready_i = 1'b0;
    n_vec++;
    chk("b2b_gnt_cycles", {20'd0, gnt_mask}, {20'd0, 12'b0001_0001_0001});
    chk("b2b_rvalid_cycles", {20'd0, rv_mask}, {20'd0, 12'b1000_1000_1000});
    chk("b2b_rdata", bus.data_rdata_o, 32'h0BAD_CAFE);

    // Reset asserted while waiting in ACCESS.
    @(negedge clk);
    bus.data_req_i  = 1'b1;
    bus.data_we_i   = 1'b0;
    bus.data_addr_i = 32'h8000_0020;
    bus.pready_i    = 1'b0;
    repeat (3) @(negedge clk);   // SETUP, ACCESS, ACCESS
    #1;
    n_vec++;
    chk("pre_reset_access", {30'd0, bus.psel_o, bus.penable_o}, 32'd3);
    #2;
    rst = 1'b1;
    #1;
    chk("async_reset_apb", {30'd0, bus.psel_o, bus.penable_o}, 32'd0);
    @(negedge clk);
    bus.data_req_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    bad = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      if (bus.data_rvalid_o || bus.psel_o) bad = 1'b1;
    end
    chk("no_rvalid_after_reset", {31'd0, bad}, 32'd0);
    run_vec(vecs[0], 7);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by 200000, expected finish");
    $fatal(1);
  end

endmodule : tb_miriscv_data2apb_bridge
